clk_tick_sync: RTL
==================

// Module: clk_tick_sync
// PURPOSE
// Downstream consumer of the ripple-divided slow clock from the t_ff divider chain.
// Brings that asynchronous slow clock into the system clk domain through a synchroniser.
// Emits a one-cycle tick_o per slow-clock rising edge and keeps a wrapping tick count.
// Flags a stalled divider (no edge within TIMEOUT cycles) so logic never clocks off a ripple output.
// PARAMETERS
// SYNC_STAGES  2    synchroniser flop count (>=2)
// CNT_W        8    width of tick_cnt_o
// TIMEOUT      1024 clk cycles without any slow-clock edge before stall_o asserts (>=4)
// PORTS
// clk          in   1      system clock; all state on its rising edge
// reset        in   1      asynchronous, active-low reset
// slow_clk_in  in   1      divided clock from divider chain; asynchronous to clk
// en           in   1      block enable
// clr_i        in   1      synchronous clear of tick_cnt_o
// tick_o       out  1      one-clk pulse per synchronised rising edge of slow_clk_in
// tick_cnt_o   out  CNT_W  ticks since reset/clr, wraps
// stall_o      out  1      divider-stalled flag
// BEHAVIOUR
// - reset low: sync chain, edge reg, timeout cnt, tick_o, tick_cnt_o, stall_o all 0 at once; state IDLE
// - sync: s[0]<=slow_clk_in ... s[N-1]; prev<=s[N-1]; rise=s[N-1]&~prev; any=s[N-1]^prev
// - latency: input high before clk edge E0 -> tick_o high for exactly the cycle after edge E(SYNC_STAGES)
// - FSM, one state register:
//   IDLE: tick_o=0, stall_o=0, counter held; en=1 -> ARM
//   ARM: wait for s[N-1]==0 (blocks spurious tick if input already high); then -> RUN, timeout cnt=0
//   RUN: rise -> tick_o=1; any -> timeout cnt=0, else +1; cnt==TIMEOUT-1 with no edge -> STALL
//   STALL: stall_o=1; any -> RUN, stall_o=0 next cycle, tick_o=1 if that edge is a rise
//   any state, en=0 -> IDLE next edge; tick_o, stall_o forced 0; tick_cnt_o retained
// - tick_cnt_o: +1 on the same edge tick_o is registered high; wraps 2^CNT_W-1 -> 0
// - clr_i and tick in the same cycle: clr wins; cnt=0; tick_o still pulses
// - timeout cnt width $clog2(TIMEOUT); saturates in STALL, never wraps
// - each slow_clk_in level must hold >= SYNC_STAGES+1 clk cycles; shorter pulses may be lost
// - stall_o is a registered level; tick_o is never high for 2 consecutive cycles
// STRUCTURE
// - package clk_tick_pkg: typedef enum logic [1:0] {IDLE,ARM,RUN,STALL} tick_state_t;
//   default constants SYNC_STAGES_DEF=2, CNT_W_DEF=8, TIMEOUT_DEF=1024
// - sub-module bit_sync (param STAGES, clk, active-low async reset) holds the synchroniser chain
// - top holds edge detect, FSM, timeout counter and tick counter
// TESTING  (SYNC_STAGES=2, CNT_W=4, TIMEOUT=16, clk period 10ns)
// 1 reset low mid-operation with stall_o=1, cnt=5 -> all outputs 0 within the cycle, before any clk edge
// 2 en=0, toggle slow_clk_in x5 -> tick_o stays 0, cnt 0; en=1, in low 3 clk, rise before edge E0
//   -> tick_o=1 for only the cycle after E2; cnt=1
// 3 slow clock period 8 clk, 17 rises -> 17 single-cycle ticks, cnt 0..15 then 0 then 1
// 4 hold input constant after last edge -> stall_o=1 16 clk after the edge is seen; next rise
//   -> stall_o=0, tick_o=1, cnt+1
// 5 en rises while input already high -> no tick; input low then high -> first tick, cnt=1
// 6 clr_i high on the tick cycle -> tick_o=1, cnt=0; next rise -> cnt=1

Source files
------------

// File: rtl/clk_tick_pkg.sv
// Shared types and defaults for the slow-clock tick synchroniser.
package clk_tick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } tick_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;
  localparam int TIMEOUT_DEF     = 1024;

  // Timeout counter width; it only has to reach TIMEOUT-1 because it saturates.
  function automatic int tmo_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/clk_tick_sync_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level.
module bit_sync
  import clk_tick_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  // Shift the asynchronous input through the chain; only the last flop is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s <= '0;
    else        s <= {s[STAGES-2:0], d};
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/clk_tick_sync.sv
// Converts a ripple-divided slow clock into single-cycle ticks in the clk domain,
// counts them, and flags a divider that has stopped toggling.
//
// state | meaning
// IDLE  | disabled; outputs low, tick count held
// ARM   | enabled, waiting for a synchronised low so a high input cannot fake a tick
// RUN   | ticking on rises; timeout counter cleared by any edge
// STALL | no edge for TIMEOUT cycles; stall_o high until the next edge
module clk_tick_sync
  import clk_tick_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  input  logic             en,
  input  logic             clr_i,
  output logic             tick_o,
  output logic [CNT_W-1:0] tick_cnt_o,
  output logic             stall_o
);

  localparam int            TW       = tmo_cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic          sync_q;
  logic          prev;
  logic          rise;
  logic          any;
  tick_state_t   state;
  tick_state_t   state_nxt;
  logic [TW-1:0] tmo;
  logic [TW-1:0] tmo_nxt;
  logic          tick_nxt;
  logic          stall_nxt;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (slow_clk_in),
    .q     (sync_q)
  );

  // Remember the previous synchronised level so edges can be seen in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= sync_q;
  end

  assign rise = sync_q & ~prev;
  assign any  = sync_q ^ prev;

  // Next-state, next tick and timeout counter; en low overrides everything.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    tick_nxt  = 1'b0;
    case (state)
      IDLE: begin
        tmo_nxt = '0;
        if (en) state_nxt = ARM;
      end
      ARM: begin
        tmo_nxt = '0;
        if (!sync_q) state_nxt = RUN;
      end
      RUN: begin
        tick_nxt = rise;
        if (any) begin
          tmo_nxt = '0;
        end else if (tmo == TMO_LAST) begin
          state_nxt = STALL;
        end else begin
          tmo_nxt = tmo + TW'(1);
        end
      end
      STALL: begin
        // Counter stays parked at TIMEOUT-1 rather than wrapping.
        if (any) begin
          state_nxt = RUN;
          tmo_nxt   = '0;
          tick_nxt  = rise;
        end
      end
      default: begin
        state_nxt = IDLE;
        tmo_nxt   = '0;
      end
    endcase
    if (!en) begin
      state_nxt = IDLE;
      tmo_nxt   = '0;
      tick_nxt  = 1'b0;
    end
  end

  assign stall_nxt = (state_nxt == STALL);

  // Register state and the two status outputs so neither glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo     <= '0;
      tick_o  <= 1'b0;
      stall_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo     <= tmo_nxt;
      tick_o  <= tick_nxt;
      stall_o <= stall_nxt;
    end
  end

  // Wrapping tick count; a clear in the tick cycle wins over the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        tick_cnt_o <= '0;
    else if (clr_i)    tick_cnt_o <= '0;
    else if (tick_nxt) tick_cnt_o <= tick_cnt_o + CNT_W'(1);
  end

endmodule
